// File: rtl/crc_pkg.sv
// Shared definitions for the CRC engine: FSM encoding, CRC-32 default constants
// and a bit-reversal helper used on the output path.
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } crc_state_t;

    localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

    // Reverses the low 'width' bits of value; bits above 'width' come back as 0.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
        logic [31:0] r;
        r = {<<{value}};
        return r >> (32 - width);
    endfunction

endpackage

// File: rtl/crc_step.sv
// One slice of the CRC: BITS_PER_CYCLE serial MSB-first LFSR steps unrolled into
// combinational logic. slice[BITS_PER_CYCLE-1] is the first bit consumed.
module crc_step
    import crc_pkg::*;
#(
    parameter int          CRC_W          = 32,
    parameter int          BITS_PER_CYCLE = 8,
    parameter logic [31:0] POLY           = CRC32_POLY
) (
    input  logic [CRC_W-1:0]          crc_cur,
    input  logic [BITS_PER_CYCLE-1:0] slice,
    output logic [CRC_W-1:0]          crc_nxt
);

    localparam logic [CRC_W-1:0] POLY_W = POLY[CRC_W-1:0];

    logic [CRC_W-1:0]          c;
    logic [BITS_PER_CYCLE-1:0] s;
    logic                      fb;

    always_comb begin
        c  = crc_cur;
        s  = slice;
        fb = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            fb = c[CRC_W-1] ^ s[BITS_PER_CYCLE-1];
            c  = {c[CRC_W-2:0], 1'b0} ^ ({CRC_W{fb}} & POLY_W);
            s  = s << 1;
        end
        crc_nxt = c;
    end

endmodule

// File: rtl/crc_engine.sv
// Streaming CRC engine: accepts message words over a valid/ready port, folds
// BITS_PER_CYCLE bits per clock and publishes the finished CRC with a done pulse.
module crc_engine
    import crc_pkg::*;
#(
    parameter int          CRC_W          = 32,
    parameter int          DATA_W         = 32,
    parameter int          BITS_PER_CYCLE = 8,
    parameter logic [31:0] POLY           = CRC32_POLY,
    parameter logic [31:0] INIT           = CRC32_INIT,
    parameter bit          REFIN          = 1'b1,
    parameter bit          REFOUT         = 1'b1,
    parameter logic [31:0] XOROUT         = CRC32_XOROUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              busy,
    output logic [CRC_W-1:0]  crc_out,
    output logic              done
);

    localparam int NSLICE = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);
    localparam logic [CRC_W-1:0] INIT_W     = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOROUT_W   = XOROUT[CRC_W-1:0];

    crc_state_t        state;
    logic [CRC_W-1:0]  crc_q;
    logic [CRC_W-1:0]  crc_nxt;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] in_ordered;
    logic              last_q;
    logic [CNT_W-1:0]  slice_cnt;
    logic [31:0]       rev_full;
    logic [CRC_W-1:0]  fin_val;

    // Bytes stay in MSB-first order; with REFIN each byte is mirrored so the
    // MSB-first shifter consumes its bits LSB first.
    for (genvar g = 0; g < DATA_W / 8; g++) begin : g_order
        assign in_ordered[g*8 +: 8] = REFIN ? {<<{in_data[g*8 +: 8]}} : in_data[g*8 +: 8];
    end

    crc_step #(
        .CRC_W          (CRC_W),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .POLY           (POLY)
    ) u_step (
        .crc_cur (crc_q),
        .slice   (word_q[DATA_W-1 -: BITS_PER_CYCLE]),
        .crc_nxt (crc_nxt)
    );

    // Output value is formed from crc_nxt because crc_q updates on the same edge.
    always_comb begin
        rev_full = bit_reverse(32'(crc_nxt), CRC_W);
        fin_val  = (REFOUT ? rev_full[CRC_W-1:0] : crc_nxt) ^ XOROUT_W;
    end

    // Handshake: a word transfers on a rising edge where in_valid and in_ready are
    // both high. in_ready is high only in WAIT, in_valid elsewhere is ignored, and
    // in_data/in_last are sampled only on that transfer edge.
    assign in_ready = (state == ST_WAIT);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            crc_q     <= '0;
            word_q    <= '0;
            last_q    <= 1'b0;
            slice_cnt <= '0;
            crc_out   <= '0;
        end else if (start) begin
            // Opens a message from any state; an open message is dropped silently.
            state     <= ST_WAIT;
            crc_q     <= INIT_W;
            slice_cnt <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (in_valid) begin
                        word_q    <= in_ordered;
                        last_q    <= in_last;
                        slice_cnt <= '0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    crc_q  <= crc_nxt;
                    word_q <= word_q << BITS_PER_CYCLE;
                    if (slice_cnt == LAST_SLICE) begin
                        slice_cnt <= '0;
                        if (last_q) begin
                            crc_out <= fin_val;
                            state   <= ST_DONE;
                        end else begin
                            state   <= ST_WAIT;
                        end
                    end else begin
                        slice_cnt <= slice_cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_engine.sv
// Bench for crc_engine: four parameterisations side by side, messages driven through
// tasks, expected CRCs queued from known check values or a bit-serial reference model.
module tb_crc_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 0: CRC-32 byte-wide, 1: CRC-16/CCITT-FALSE byte-wide,
    // 2: CRC-32 32-bit words 8 bits/cycle, 3: CRC-32 32-bit words 1 bit/cycle
    logic        start_v [4];
    logic        valid_v [4];
    logic        last_v  [4];
    logic [31:0] data_v  [4];
    logic        rdy_v   [4];
    logic        busy_v  [4];
    logic        done_v  [4];
    logic [31:0] crc0, crc2, crc3;
    logic [15:0] crc1;

    int checks = 0;
    int failures = 0;
    int done_cnt [4] = '{0, 0, 0, 0};
    int acc_cnt  [4] = '{0, 0, 0, 0};

    logic [31:0] exp_q[$];
    logic [31:0] msg_q[$];
    logic [7:0]  mbytes[$];

    crc_engine #(.DATA_W(8)) u_crc32_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_data(data_v[0][7:0]),
        .in_valid(valid_v[0]), .in_last(last_v[0]), .in_ready(rdy_v[0]),
        .busy(busy_v[0]), .crc_out(crc0), .done(done_v[0]));

    crc_engine #(.CRC_W(16), .DATA_W(8), .POLY(32'h1021), .INIT(32'hFFFF),
                 .REFIN(1'b0), .REFOUT(1'b0), .XOROUT(32'h0)) u_crc16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_data(data_v[1][7:0]),
        .in_valid(valid_v[1]), .in_last(last_v[1]), .in_ready(rdy_v[1]),
        .busy(busy_v[1]), .crc_out(crc1), .done(done_v[1]));

    crc_engine #(.DATA_W(32), .BITS_PER_CYCLE(8)) u_crc32_w8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_data(data_v[2]),
        .in_valid(valid_v[2]), .in_last(last_v[2]), .in_ready(rdy_v[2]),
        .busy(busy_v[2]), .crc_out(crc2), .done(done_v[2]));

    crc_engine #(.DATA_W(32), .BITS_PER_CYCLE(1)) u_crc32_w1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .in_data(data_v[3]),
        .in_valid(valid_v[3]), .in_last(last_v[3]), .in_ready(rdy_v[3]),
        .busy(busy_v[3]), .crc_out(crc3), .done(done_v[3]));

    // Monitor on the inactive edge: counts done pulses and accepted words.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_v[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
            if (valid_v[i] === 1'b1 && rdy_v[i] === 1'b1) acc_cnt[i] <= acc_cnt[i] + 1;
        end
    end

    function automatic logic [31:0] crc_of(input int sel);
        case (sel)
            0:       return crc0;
            1:       return {16'h0, crc1};
            2:       return crc2;
            default: return crc3;
        endcase
    endfunction

    function automatic int nslice(input int sel);
        return (sel == 3) ? 32 : ((sel == 2) ? 4 : 1);
    endfunction

    // Textbook bit-serial CRC over mbytes.
    function automatic logic [31:0] ref_crc(input int sel);
        int          w;
        logic [31:0] poly, mask, c, xo;
        bit          refl, fb;
        logic [7:0]  b;
        w    = (sel == 1) ? 16 : 32;
        poly = (sel == 1) ? 32'h1021 : 32'h04C11DB7;
        mask = (sel == 1) ? 32'h0000FFFF : 32'hFFFFFFFF;
        c    = (sel == 1) ? 32'h0000FFFF : 32'hFFFFFFFF;
        xo   = (sel == 1) ? 32'h0 : 32'hFFFFFFFF;
        refl = (sel != 1);
        foreach (mbytes[k]) begin
            b = refl ? {<<{mbytes[k]}} : mbytes[k];
            for (int i = 0; i < 8; i++) begin
                fb = c[w-1] ^ b[7];
                c  = (c << 1) & mask;
                if (fb) c = c ^ (poly & mask);
                b  = b << 1;
            end
        end
        if (refl) c = {<<{c}} >> (32 - w);
        return (c ^ xo) & mask;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic build_bytes(input int sel);
        mbytes.delete();
        foreach (msg_q[i]) begin
            if (sel >= 2) begin
                mbytes.push_back(msg_q[i][31:24]);
                mbytes.push_back(msg_q[i][23:16]);
                mbytes.push_back(msg_q[i][15:8]);
            end
            mbytes.push_back(msg_q[i][7:0]);
        end
    endtask

    task automatic queue_exp_model(input int sel);
        build_bytes(sel);
        exp_q.push_back(ref_crc(sel));
    endtask

    task automatic load_check_string();
        msg_q.delete();
        for (int i = 0; i < 9; i++) msg_q.push_back(32'h31 + 32'(i));
    endtask

    task automatic do_start(input int sel);
        start_v[sel] = 1'b1;
        cyc();
        start_v[sel] = 1'b0;
    endtask

    task automatic send_word(input int sel, input logic [31:0] w, input bit last, input bit hold);
        int n = 0;
        data_v[sel]  = w;
        last_v[sel]  = last;
        valid_v[sel] = 1'b1;
        while (rdy_v[sel] !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        checks++;
        if (rdy_v[sel] !== 1'b1) begin
            failures++;
            $display("FAIL ready_timeout sel=%0d in_ready=%b required 1", sel, rdy_v[sel]);
        end
        cyc();
        if (!hold) valid_v[sel] = 1'b0;
    endtask

    // Sends msg_q as one message, then checks latency, CRC and the done pulse.
    task automatic run_msg(input int sel, input bit with_start, input bit hold, input string name);
        int          k, d0;
        logic [31:0] e;
        d0 = done_cnt[sel];
        if (with_start) do_start(sel);
        foreach (msg_q[i]) send_word(sel, msg_q[i], (i == msg_q.size() - 1), hold);
        k = 1;
        while (done_v[sel] !== 1'b1 && k < 200) begin
            cyc();
            k++;
        end
        checks++;
        if (k != nslice(sel) + 1) begin
            failures++;
            $display("FAIL %s_latency cycles=%0d required %0d", name, k, nslice(sel) + 1);
        end
        e = exp_q.pop_front();
        checks++;
        if (crc_of(sel) !== e) begin
            failures++;
            $display("FAIL %s_crc crc_out=%h required %h", name, crc_of(sel), e);
        end
        cyc();
        valid_v[sel] = 1'b0;
        last_v[sel]  = 1'b0;
        checks++;
        if (done_v[sel] !== 1'b0 || busy_v[sel] !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_width done=%b busy=%b required 0 0", name, done_v[sel], busy_v[sel]);
        end
        checks++;
        if (done_cnt[sel] != d0 + 1 || crc_of(sel) !== e) begin
            failures++;
            $display("FAIL %s_done_hold pulses=%0d crc_out=%h required 1 %h",
                     name, done_cnt[sel] - d0, crc_of(sel), e);
        end
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (rdy_v[s] !== 1'b0 || busy_v[s] !== 1'b0 || done_v[s] !== 1'b0 || crc_of(s) !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs sel=%0d ready=%b busy=%b done=%b crc=%h required all 0",
                         s, rdy_v[s], busy_v[s], done_v[s], crc_of(s));
            end
        end
        start_v[0] = 1'b1;
        cyc();
        start_v[0] = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_start_ignored busy=%b required 0", busy_v[0]);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_check_values();
        load_check_string();
        exp_q.push_back(32'hCBF43926);
        run_msg(0, 1'b1, 1'b0, "crc32_check");
        load_check_string();
        exp_q.push_back(32'h000029B1);
        run_msg(1, 1'b1, 1'b0, "crc16_check");
    endtask

    task automatic test_bpc_equiv();
        msg_q.delete();
        msg_q.push_back(32'h12345678);
        msg_q.push_back(32'hABCDE123);
        queue_exp_model(2);
        run_msg(2, 1'b1, 1'b0, "w32_bpc8");
        queue_exp_model(3);
        run_msg(3, 1'b1, 1'b0, "w32_bpc1");
        checks++;
        if (crc2 !== crc3) begin
            failures++;
            $display("FAIL bpc_equiv bpc8=%h required bpc1 %h", crc2, crc3);
        end
    endtask

    task automatic test_abort();
        int d0 = done_cnt[0];
        do_start(0);
        for (int i = 0; i < 3; i++) send_word(0, 32'($urandom_range(0, 255)), 1'b0, 1'b0);
        checks++;
        if (busy_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy busy=%b required 1", busy_v[0]);
        end
        load_check_string();
        exp_q.push_back(32'hCBF43926);
        run_msg(0, 1'b1, 1'b0, "abort");
        checks++;
        if (done_cnt[0] != d0 + 1) begin
            failures++;
            $display("FAIL abort_pulses pulses=%0d required 1", done_cnt[0] - d0);
        end
    endtask

    task automatic test_backpressure();
        int a0 = acc_cnt[2];
        msg_q.delete();
        msg_q.push_back(32'hA5A5F00F);
        msg_q.push_back(32'h0BADCAFE);
        msg_q.push_back(32'h12345678);
        queue_exp_model(2);
        run_msg(2, 1'b1, 1'b1, "backpressure");
        checks++;
        if (acc_cnt[2] - a0 != 3) begin
            failures++;
            $display("FAIL backpressure_accepts accepts=%0d required 3", acc_cnt[2] - a0);
        end
    endtask

    task automatic test_reset_mid();
        int d0 = done_cnt[2];
        do_start(2);
        send_word(2, 32'hDEADBEEF, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdy_v[2] !== 1'b0 || busy_v[2] !== 1'b0 || done_v[2] !== 1'b0 || crc2 !== 32'h0 || crc0 !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs ready=%b busy=%b done=%b crc=%h crc0=%h required all 0",
                     rdy_v[2], busy_v[2], done_v[2], crc2, crc0);
        end
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (8) cyc();
        checks++;
        if (busy_v[2] !== 1'b0 || done_cnt[2] != d0) begin
            failures++;
            $display("FAIL reset_mid_discard busy=%b pulses=%0d required 0 0", busy_v[2], done_cnt[2] - d0);
        end
        msg_q.delete();
        msg_q.push_back(32'hDEADBEEF);
        msg_q.push_back(32'h00C0FFEE);
        queue_exp_model(2);
        run_msg(2, 1'b1, 1'b0, "after_reset");
    endtask

    task automatic test_random_back_to_back();
        for (int r = 0; r < 8; r++) begin
            int sel = r % 2;
            int len = $urandom_range(1, 12);
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(32'($urandom_range(0, 255)));
            queue_exp_model(sel);
            run_msg(sel, 1'b1, 1'b0, "random");
        end
    endtask

    task automatic test_start_in_done();
        int          k, d0;
        logic [31:0] e;
        msg_q.delete();
        for (int i = 0; i < 3; i++) msg_q.push_back(32'($urandom_range(0, 255)));
        queue_exp_model(0);
        d0 = done_cnt[0];
        do_start(0);
        foreach (msg_q[i]) send_word(0, msg_q[i], (i == msg_q.size() - 1), 1'b0);
        k = 1;
        while (done_v[0] !== 1'b1 && k < 200) begin
            cyc();
            k++;
        end
        start_v[0] = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if (crc0 !== e || done_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL start_in_done_crc crc_out=%h done=%b required %h 1", crc0, done_v[0], e);
        end
        cyc();
        start_v[0] = 1'b0;
        checks++;
        if (done_cnt[0] != d0 + 1 || rdy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL start_in_done_state pulses=%0d ready=%b done=%b required 1 1 0",
                     done_cnt[0] - d0, rdy_v[0], done_v[0]);
        end
        msg_q.delete();
        for (int i = 0; i < 4; i++) msg_q.push_back(32'($urandom_range(0, 255)));
        queue_exp_model(0);
        run_msg(0, 1'b0, 1'b0, "restart_from_done");
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            start_v[i] = 1'b0;
            valid_v[i] = 1'b0;
            last_v[i]  = 1'b0;
            data_v[i]  = 32'h0;
        end
        test_reset();
        test_check_values();
        test_bpc_equiv();
        test_abort();
        test_backpressure();
        test_reset_mid();
        test_random_back_to_back();
        test_start_in_done();
        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/crc_engine.md
CRC_ENGINE -- requirements
Module: crc_engine

Interface
REQ-001 Parameter CRC_W, default 32, CRC register width; legal range 8..32.
REQ-002 Parameter DATA_W, default 32, input word width; multiple of 8.
REQ-003 Parameter BITS_PER_CYCLE, default 8, bits folded per clock; must divide DATA_W.
REQ-004 Parameter POLY, default 32'h04C11DB7, generator polynomial in normal form, low CRC_W bits used.
REQ-005 Parameter INIT, default 32'hFFFFFFFF, register preset at message start.
REQ-006 Parameter REFIN, default 1, reflect each input byte.
REQ-007 Parameter REFOUT, default 1, reflect final register before XOROUT.
REQ-008 Parameter XOROUT, default 32'hFFFFFFFF, final XOR mask.
REQ-009 clk  input  1  single clock; all state updates on its rising edge.
REQ-010 rst_n  input  1  asynchronous, active-low reset.
REQ-011 start  input  1  one-cycle pulse; opens a new message.
REQ-012 in_data  input  DATA_W  message word.
REQ-013 in_valid  input  1  in_data and in_last are valid.
REQ-014 in_last  input  1  the current word is the final word of the message.
REQ-015 in_ready  output  1  engine accepts a word this cycle.
REQ-016 busy  output  1  a message is open (not IDLE).
REQ-017 crc_out  output  CRC_W  final CRC of the last completed message.
REQ-018 done  output  1  one-cycle pulse; crc_out has just been updated.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT, SHIFT and DONE.
REQ-020 Transitions SHALL be: IDLE to WAIT on start; WAIT to SHIFT on in_valid and in_ready; SHIFT to WAIT after the last slice of a non-final word; SHIFT to DONE after the last slice of a final word; DONE to IDLE unconditionally.
REQ-021 On start, the CRC register SHALL load INIT in the same edge that enters WAIT.
REQ-022 start in any state other than IDLE SHALL abort the open message, reload INIT and enter WAIT, with no done pulse.
REQ-023 in_ready SHALL be 1 exactly when state is WAIT; in_data and in_last SHALL be captured only on the accepting edge.
REQ-024 SHIFT SHALL last exactly DATA_W/BITS_PER_CYCLE cycles per word, counted by a slice counter that resets on each accept.
REQ-025 Bytes SHALL be consumed most-significant byte first; when REFIN=1, bits within each byte SHALL be consumed LSB first, otherwise MSB first.
REQ-026 Each slice update SHALL be bit-exact to BITS_PER_CYCLE sequential MSB-first LFSR steps with POLY; the result SHALL be independent of BITS_PER_CYCLE.
REQ-027 On the DONE-entry edge, crc_out SHALL load (REFOUT ? reverse(reg) : reg) XOR XOROUT, truncated to CRC_W bits.
REQ-028 done SHALL be 1 only in the single cycle in DONE; crc_out SHALL hold its value until the next DONE.
REQ-029 The latency from the accept of the final word to done high SHALL be DATA_W/BITS_PER_CYCLE + 1 cycles.
REQ-030 A new message SHALL be startable in the cycle after done (in IDLE); start asserted during DONE SHALL be treated as in REQ-022, without suppressing the done pulse.
REQ-031 in_valid while not in WAIT SHALL be ignored; messages SHALL contain at least one word.

Reset
REQ-032 rst_n low SHALL immediately force state to IDLE, the CRC register to 0, the slice counter to 0, and crc_out, done, in_ready and busy to 0.
REQ-033 Reset in mid-message SHALL discard that message without a done pulse; operation SHALL resume only after a new start.

Structure
REQ-034 The package crc_pkg SHALL hold the FSM state enum typedef, the default CRC-32 constants (POLY, INIT, XOROUT) and a bit-reverse function.
REQ-035 A combinational sub-module crc_step (CRC_W, BITS_PER_CYCLE, POLY) SHALL perform one slice update; crc_engine SHALL hold the FSM, counter and registers.

Verification
REQ-036 Default parameters, DATA_W=8: start, then bytes 31..39 ("123456789") with in_last on 39 -> crc_out=32'hCBF43926, with done high for exactly one cycle.
REQ-037 CRC_W=16, POLY=16'h1021, INIT=16'hFFFF, REFIN=0, REFOUT=0, XOROUT=0, DATA_W=8: bytes "123456789" -> crc_out=16'h29B1.
REQ-038 DATA_W=32, BITS_PER_CYCLE=1 vs 8, same words 32'h12345678 and 32'hABCDE123 (last) -> identical crc_out; done 33 and 5 cycles after the final accept, respectively.
REQ-039 Abort: start, 3 bytes, start again, then "123456789" -> no intermediate done; crc_out=32'hCBF43926.
REQ-040 Backpressure and reset: in_valid held high while in SHIFT -> no extra accept; rst_n low during SHIFT -> outputs 0 at once, then a full run after a new start -> correct CRC.
